// File: rtl/weight_loader_pkg.sv
// Shared types and constants for the weight loader: FSM state encoding,
// default beat/line geometry and small helper functions.
package weight_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_BEAT_W = 512;
  localparam int DEF_LINE_W = 4096;

  function automatic int beats_per_line(input int line_w, input int beat_w);
    return line_w / beat_w;
  endfunction

  localparam int BEATS_PER_LINE = beats_per_line(DEF_LINE_W, DEF_BEAT_W);

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/weight_loader_line_packer.sv
// Beat-to-line assembly register: each accepted beat lands in slot beat_cnt,
// beat 0 in the least-significant slot; line_full_o flags the closing beat.
module line_packer
  import weight_loader_pkg::*;
#(
  parameter int BEAT_W = DEF_BEAT_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [BEAT_W-1:0] beat_i,
  output logic [LINE_W-1:0] line_o,
  output logic              line_full_o
);

  localparam int BEATS = beats_per_line(LINE_W, BEAT_W);
  localparam int CNT_W = cnt_width(BEATS);

  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LINE_W-1:0] line_q;
  logic              last_slot;

  assign last_slot   = (beat_cnt_q == CNT_W'(BEATS - 1));
  assign line_full_o = wr_en_i && last_slot;
  assign line_o      = line_q;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (clr_i) begin
      beat_cnt_d = '0;
    end else if (wr_en_i) begin
      beat_cnt_d = last_slot ? '0 : beat_cnt_q + 1'b1;
    end
  end

  // Line contents are cleared on reset so a discarded partial line never reaches the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      line_q     <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      if (wr_en_i) begin
        line_q[int'(beat_cnt_q)*BEAT_W +: BEAT_W] <= beat_i;
      end
    end
  end

endmodule

// File: rtl/weight_loader.sv
// Weight loader: packs DRAM beats into weight-buffer lines and writes them at
// consecutive addresses. Optional busy-cycle counter: WEIGHT_LOADER_PERF_CNT_EN.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int BEAT_W = DEF_BEAT_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_start,
  input  logic [ADDR_W-1:0] in_base_addr,
  input  logic [ADDR_W:0]   in_num_lines,
  output logic              out_busy,
  output logic              out_done,
  input  logic              in_beat_valid,
  input  logic [BEAT_W-1:0] in_beat_data,
  output logic              out_beat_ready,
  output logic              out_dram_req,
  output logic              out_dram_we,
  output logic [ADDR_W-1:0] out_dram_addr,
  output logic [LINE_W-1:0] out_dram_wdata
`ifdef WEIGHT_LOADER_PERF_CNT_EN
  ,
  output logic [31:0]       out_busy_cycles
`endif
);

  localparam logic [ADDR_W:0] MAX_LINES = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   line_cnt_q, line_cnt_d;
  logic [ADDR_W:0]   num_eff;
  logic              start_acc;
  logic              beat_xfer;
  logic              pack_clr;
  logic              line_full;

  assign num_eff   = (in_num_lines > MAX_LINES) ? MAX_LINES : in_num_lines;
  assign start_acc = (state_q == IDLE) && in_start;
  assign beat_xfer = (state_q == FILL) && in_beat_valid;

  line_packer #(
    .BEAT_W (BEAT_W),
    .LINE_W (LINE_W)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (pack_clr),
    .wr_en_i     (beat_xfer),
    .beat_i      (in_beat_data),
    .line_o      (out_dram_wdata),
    .line_full_o (line_full)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    line_cnt_d = line_cnt_q;
    addr_d     = addr_q;
    pack_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_start) begin
          base_d     = in_base_addr;
          count_d    = num_eff;
          line_cnt_d = '0;
          pack_clr   = 1'b1;
          state_d    = (num_eff == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (line_full) begin
          // Address is latched on entry to WRITE so the request fields all come from registers.
          addr_d  = base_q + line_cnt_q[ADDR_W-1:0];
          state_d = WRITE;
        end
      end
      WRITE: begin
        line_cnt_d = line_cnt_q + 1'b1;
        state_d    = (line_cnt_q == count_q - 1'b1) ? DONE : FILL;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      line_cnt_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      line_cnt_q <= line_cnt_d;
      addr_q     <= addr_d;
    end
  end

  assign out_busy       = (state_q == FILL) || (state_q == WRITE);
  assign out_done       = (state_q == DONE);
  assign out_beat_ready = (state_q == FILL);
  assign out_dram_req   = (state_q == WRITE);
  assign out_dram_we    = (state_q == WRITE);
  assign out_dram_addr  = addr_q;

`ifdef WEIGHT_LOADER_PERF_CNT_EN
  logic [31:0] busy_cnt_q, busy_cnt_d;

  // The start cycle is included so the total spans start through the final write.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (start_acc) begin
      busy_cnt_d = (num_eff != '0) ? 32'd1 : 32'd0;
    end else if (out_busy) begin
      busy_cnt_d = sat_inc32(busy_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt_q <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign out_busy_cycles = busy_cnt_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Directed self-checking bench for weight_loader: single line, address wrap,
// backpressure, zero count / ignored start, and mid-line reset.
module tb_weight_loader;

  localparam int BEAT_W = 512;
  localparam int LINE_W = 4096;
  localparam int ADDR_W = 8;
  localparam int BEATS  = weight_loader_pkg::BEATS_PER_LINE;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_start;
  logic [ADDR_W-1:0] in_base_addr;
  logic [ADDR_W:0]   in_num_lines;
  logic              out_busy;
  logic              out_done;
  logic              in_beat_valid;
  logic [BEAT_W-1:0] in_beat_data;
  logic              out_beat_ready;
  logic              out_dram_req;
  logic              out_dram_we;
  logic [ADDR_W-1:0] out_dram_addr;
  logic [LINE_W-1:0] out_dram_wdata;
`ifdef WEIGHT_LOADER_PERF_CNT_EN
  logic [31:0]       out_busy_cycles;
`endif

  weight_loader #(
    .BEAT_W (BEAT_W),
    .LINE_W (LINE_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_start       (in_start),
    .in_base_addr   (in_base_addr),
    .in_num_lines   (in_num_lines),
    .out_busy       (out_busy),
    .out_done       (out_done),
    .in_beat_valid  (in_beat_valid),
    .in_beat_data   (in_beat_data),
    .out_beat_ready (out_beat_ready),
    .out_dram_req   (out_dram_req),
    .out_dram_we    (out_dram_we),
    .out_dram_addr  (out_dram_addr),
    .out_dram_wdata (out_dram_wdata)
`ifdef WEIGHT_LOADER_PERF_CNT_EN
    ,
    .out_busy_cycles (out_busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int viol   = 0;
  int t0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [LINE_W-1:0] wr_data[$];
  int                wr_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_dram_req) begin
      wr_addr.push_back(out_dram_addr);
      wr_data.push_back(out_dram_wdata);
      wr_cyc.push_back(cyc);
      if (out_beat_ready || !out_dram_we) viol++;
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] pat(input int s);
    logic [7:0] b;
    b = 8'(s + 1);
    return {(BEAT_W/8){b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] num,
                           output int t_start);
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    viol         = 0;
    in_base_addr = base;
    in_num_lines = num;
    in_start     = 1'b1;
    t_start      = cyc;
    tick();
    in_start     = 1'b0;
  endtask

  // Presents beats seed, seed+1, ...; a beat advances only when ready and valid coincide.
  task automatic feed(input int total, input int seed, input bit toggle, input int inj_at);
    int got   = 0;
    int guard = 0;
    bit ph    = 1'b1;
    bit inj   = 1'b0;
    bit x;
    while (got < total && guard < 400) begin
      in_beat_data  = pat(seed + got);
      in_beat_valid = toggle ? ph : 1'b1;
      if (!inj && got == inj_at) begin
        in_start     = 1'b1;
        in_base_addr = 8'h80;
        in_num_lines = 9'd1;
        inj          = 1'b1;
      end
      x = out_beat_ready && in_beat_valid;
      tick();
      in_start = 1'b0;
      if (x) got++;
      ph = ~ph;
      guard++;
    end
    in_beat_valid = 1'b0;
    if (got < total) check("feed_timeout", got, total);
  endtask

  task automatic wait_done(input int t_start, input int exp_rel, input string tag);
    int n = 0;
    while (!out_done && n < 200) begin
      tick();
      n++;
    end
    if (exp_rel >= 0) check(tag, out_done ? (cyc - t_start) : -1, exp_rel);
    else              check(tag, out_done, 1'b1);
    check({tag, "_busy"}, out_busy, 1'b0);
  endtask

  task automatic check_line(input string tag, input int idx, input int seed);
    if (wr_data.size() > idx) begin
      for (int k = 0; k < BEATS; k++) begin
        check($sformatf("%s_l%0d_s%0d", tag, idx, k), wr_data[idx][k*BEAT_W +: BEAT_W],
              pat(seed + k));
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    in_start      = 1'b0;
    in_base_addr  = '0;
    in_num_lines  = '0;
    in_beat_valid = 1'b0;
    in_beat_data  = '0;
    tick();
    tick();
    check("rst_busy",  out_busy, 1'b0);
    check("rst_done",  out_done, 1'b0);
    check("rst_ready", out_beat_ready, 1'b0);
    check("rst_req",   out_dram_req, 1'b0);
    check("rst_we",    out_dram_we, 1'b0);
    check("rst_addr",  out_dram_addr, 8'h00);
    check("rst_wdata", out_dram_wdata[511:0], '0);
    rst = 1'b0;
    tick();

    // Single line
    start_job(8'h10, 9'd1, t0);
    check("t1_busy_c1",  out_busy, 1'b1);
    check("t1_ready_c1", out_beat_ready, 1'b1);
    feed(8, 0, 1'b0, -1);
    wait_done(t0, 10, "t1_done_cyc");
    check("t1_nwr", wr_addr.size(), 1);
    if (wr_addr.size() >= 1) begin
      check("t1_addr", wr_addr[0], 8'h10);
      check("t1_wcyc", wr_cyc[0] - t0, 9);
    end
    check_line("t1", 0, 0);
    tick();

    // Address wrap
    start_job(8'hFE, 9'd3, t0);
    feed(24, 0, 1'b0, -1);
    wait_done(t0, 28, "t2_done_cyc");
    check("t2_nwr", wr_addr.size(), 3);
    if (wr_addr.size() >= 3) begin
      check("t2_addr0", wr_addr[0], 8'hFE);
      check("t2_addr1", wr_addr[1], 8'hFF);
      check("t2_addr2", wr_addr[2], 8'h00);
      check("t2_wcyc2", wr_cyc[2] - t0, 27);
    end
    check_line("t2", 1, 8);
    check_line("t2", 2, 16);
    tick();

    // Backpressure
    start_job(8'h05, 9'd2, t0);
    feed(16, 100, 1'b1, -1);
    wait_done(t0, -1, "t3_done");
    check("t3_nwr", wr_addr.size(), 2);
    check("t3_ready_in_write", viol, 0);
    if (wr_addr.size() >= 2) begin
      check("t3_addr0", wr_addr[0], 8'h05);
      check("t3_addr1", wr_addr[1], 8'h06);
    end
    check_line("t3", 0, 100);
    check_line("t3", 1, 108);
    tick();

    // Zero count
    start_job(8'h33, 9'd0, t0);
    wait_done(t0, 1, "t4_zero_done");
    check("t4_zero_nwr", wr_addr.size(), 0);
    tick();

    // Start during FILL is ignored
    start_job(8'h40, 9'd2, t0);
    feed(16, 50, 1'b0, 3);
    wait_done(t0, 19, "t4_ign_done");
    check("t4_ign_nwr", wr_addr.size(), 2);
    if (wr_addr.size() >= 2) begin
      check("t4_ign_addr0", wr_addr[0], 8'h40);
      check("t4_ign_addr1", wr_addr[1], 8'h41);
    end
    check_line("t4", 1, 58);
`ifdef WEIGHT_LOADER_PERF_CNT_EN
    check("perf_at_done", out_busy_cycles, 32'd19);
    tick();
    start_job(8'h00, 9'd0, t0);
    check("perf_cleared", out_busy_cycles, 32'd0);
    wait_done(t0, 1, "perf_zero_done");
`endif
    tick();

    // Reset mid-line
    start_job(8'h20, 9'd1, t0);
    feed(5, 7, 1'b0, -1);
    rst = 1'b1;
    #1;
    check("t5_busy",  out_busy, 1'b0);
    check("t5_ready", out_beat_ready, 1'b0);
    check("t5_req",   out_dram_req, 1'b0);
    check("t5_addr",  out_dram_addr, 8'h00);
    check("t5_wdata", out_dram_wdata[511:0], '0);
    tick();
    rst = 1'b0;
    tick();
    check("t5_nwr_partial", wr_addr.size(), 0);
    start_job(8'h30, 9'd1, t0);
    feed(8, 200, 1'b0, -1);
    wait_done(t0, 10, "t5_done_cyc");
    check("t5_nwr", wr_addr.size(), 1);
    if (wr_addr.size() >= 1) check("t5_addr_new", wr_addr[0], 8'h30);
    check_line("t5", 0, 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
# weight_loader

Upstream feeder of the weight buffer. It accepts a burst command, collects 512-bit DRAM read beats over a valid/ready stream, and packs every 8 beats into one 4096-bit line. Each completed line is issued to the weight buffer's DRAM-side write port as a single-cycle write request at consecutive line addresses. Completion is signalled with a done pulse to the controller.

## Interface
- BEAT_W, 512, DRAM beat width in bits
- LINE_W, 4096, weight-buffer line width in bits; must be an integer multiple of BEAT_W
- ADDR_W, 8, weight-buffer line address width
- clk  in  1  clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- in_start  in  1  one-cycle command strobe; sampled only in IDLE
- in_base_addr  in  ADDR_W  first line address; captured on an accepted start
- in_num_lines  in  ADDR_W+1  line count, 0..256; values above 256 are treated as 256
- out_busy  out  1  high from the cycle after an accepted start until done
- out_done  out  1  one-cycle completion pulse
- in_beat_valid  in  1  DRAM beat valid
- in_beat_data  in  BEAT_W  DRAM beat payload
- out_beat_ready  out  1  beat accept; a transfer occurs when valid and ready are both high
- out_dram_req  out  1  write request to the weight buffer
- out_dram_we  out  1  write enable; always equal to out_dram_req
- out_dram_addr  out  ADDR_W  destination line address
- out_dram_wdata  out  LINE_W  packed line

## Operation
- BEATS = LINE_W/BEAT_W, which is 8 by default. beat_cnt is log2(BEATS) bits wide. line_cnt is ADDR_W+1 bits wide.
- The FSM has four states: IDLE, FILL, WRITE, DONE.
- IDLE
  - An in_start captures base and count, and clears beat_cnt and line_cnt.
  - If the count is 0, the next state is DONE. Otherwise the next state is FILL.
- FILL
  - out_beat_ready is 1.
  - Each transfer writes the beat into line slot beat_cnt, with beat 0 at bits [BEAT_W-1:0], then increments beat_cnt.
  - The transfer that carries beat BEATS-1 moves the FSM to WRITE.
- WRITE
  - Lasts exactly one cycle, with out_beat_ready at 0.
  - out_dram_req, out_dram_we, out_dram_addr and out_dram_wdata are driven from registers. out_dram_addr = (base + line_cnt) mod 2^ADDR_W, so addresses wrap past 255.
  - line_cnt then increments. If line_cnt == count-1, the next state is DONE. Otherwise the next state is FILL.
- DONE
  - out_done is 1 for one cycle, then the FSM returns to IDLE.
- in_start while the FSM is not in IDLE is ignored and has no side effects.
- Beats presented outside FILL are not accepted, because ready is 0.
- Reset forces the FSM to IDLE from any state, including mid-line. All outputs go to 0 and any partial line is discarded. No write is issued for a partial line.
- Any write to the buffer has priority over dispatcher reads at the buffer. The controller must not schedule dispatcher reads of lines still being loaded.

## Timing
- Reset value of every output is 0.
- All outputs are registered, or decoded directly from the state register with no input-to-output combinational path. out_beat_ready is (state==FILL).
- With start accepted at cycle 0:
  - out_busy rises at cycle 1.
  - out_beat_ready rises at cycle 1.
  - With continuous valid, beats are accepted on cycles 1..8.
  - The first write is at cycle 9.
- Sustained throughput is one line per BEATS+1 cycles.
- For N>0 lines with no stalls, the last write is at cycle 9N.
- out_done is asserted at cycle 9N+1. out_busy falls in the same cycle.
- For N=0, out_done is asserted at cycle 1 and no write is issued.
- A deasserted in_beat_valid stalls FILL indefinitely, with no timeout.

## Configuration
- WEIGHT_LOADER_PERF_CNT_EN
  - Defined: adds output out_busy_cycles [31:0]. It is cleared on an accepted start and increments every cycle while out_busy is high. It saturates at 2^32-1, holds its value after done, and resets to 0.
  - Undefined: the port and counter do not exist.

## Structure
- Shared package weight_loader_pkg holds the FSM state encoding (IDLE/FILL/WRITE/DONE) and the BEATS_PER_LINE localparam derived from LINE_W/BEAT_W.
- One sub-module, line_packer: the beat-to-line shift/slot register with beat_cnt. It reports a line_full flag and exposes the packed line. The FSM and address generation stay in weight_loader.

## Test plan
- Single line: start with base=0x10, num=1, and 8 beats where beat k = {64{8'(k+1)}} -> exactly one write at addr 0x10 with wdata slice k equal to beat k, then done at cycle 10.
- Wrap: base=0xFE, num=3, continuous beats -> writes to 0xFE, 0xFF, 0x00 in order, no other requests, and done at cycle 28.
- Backpressure: num=2 with valid toggled every other cycle -> both lines correct and each write exactly one cycle. out_beat_ready is 0 in WRITE and beats held there are not consumed.
- Zero count and ignored start: num=0 -> done at cycle 1 with no writes. A second start during FILL of a num=2 job -> no change to the addresses or line count.
- Reset mid-line: reset asserted after 5 beats -> all outputs 0, no write issued. A fresh num=1 job afterward writes a line containing only the new beats.
- Perf counter with WEIGHT_LOADER_PERF_CNT_EN: num=2, no stalls -> out_busy_cycles = 19 at done. Next start clears it to 0.
